// File: rtl/fp_check_queue.sv
// ---------------------------------------------------------------------------
// fp_check_queue
//
// Scoreboard that sits beside an fp_unit under test. Every operation issued
// to the unit pushes its expected {result, flags, fmt, relax, last} entry
// into an in-order queue; every result the unit produces pops the head entry
// and compares against it. The first error (mismatch, underflow, overflow)
// or a clean compare of the entry marked "last" ends the test.
//
// Optional feature (macro FP_CHECK_NAN_RELAX_EN):
//   When defined, an entry pushed with push_relax=1 accepts the canonical
//   quiet NaN from the unit as a match for any NaN with the same
//   exponent/quiet bits, ignoring payload and sign. When undefined, the
//   compare is an exact bitwise compare and relax/fmt are not stored.
//
// Parameters:
//   DEPTH        outstanding expected entries (power of 2, 2..64)
//
// Ports:
//   clock        single clock, rising edge
//   reset        asynchronous active-high reset
//   push_valid   an operation is issued this cycle, enqueue its expectation
//   push_result  expected 64-bit result
//   push_flags   expected exception flags
//   push_fmt     0 = single precision, otherwise double
//   push_relax   NaN-relaxed compare allowed for this entry
//   push_last    final vector marker
//   dut_ready    fp_unit result valid this cycle (pops the head entry)
//   dut_result   fp_unit result
//   dut_flags    fp_unit flags
//   push_ready   queue can accept push_valid this cycle
//   done         sticky, test finished
//   fail         sticky, test failed (qualified by done)
//   err_code     0 none, 1 mismatch, 2 underflow, 3 overflow
//   diff_result  result difference captured at a failing compare
//   diff_flags   flag difference captured at a failing compare
//   check_count  number of matching compares (saturating)
// ---------------------------------------------------------------------------
module fp_check_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_valid,
    input  logic [63:0] push_result,
    input  logic [4:0]  push_flags,
    input  logic [1:0]  push_fmt,
    input  logic        push_relax,
    input  logic        push_last,
    input  logic        dut_ready,
    input  logic [63:0] dut_result,
    input  logic [4:0]  dut_flags,
    output logic        push_ready,
    output logic        done,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [63:0] diff_result,
    output logic [4:0]  diff_flags,
    output logic [31:0] check_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    localparam logic [1:0] ErrNone      = 2'd0;
    localparam logic [1:0] ErrMismatch  = 2'd1;
    localparam logic [1:0] ErrUnderflow = 2'd2;
    localparam logic [1:0] ErrOverflow  = 2'd3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic [1:0]    errCode_q, errCode_d;
    logic [63:0]   diffResult_q, diffResult_d;
    logic [4:0]    diffFlags_q, diffFlags_d;
    logic [31:0]   checkCount_q, checkCount_d;

    logic [63:0] resultMem_q [DEPTH];
    logic [4:0]  flagsMem_q  [DEPTH];
    logic        lastMem_q   [DEPTH];

    logic [63:0] expResult;
    logic [4:0]  expFlags;
    logic        expLast;
    logic [63:0] cmpDiffResult;
    logic [4:0]  cmpDiffFlags;

    logic inRun;
    logic underflow;
    logic overflow;
    logic popOk;
    logic mismatch;
    logic doPush;
    logic doPop;

`ifdef FP_CHECK_NAN_RELAX_EN
    logic [1:0]  fmtMem_q   [DEPTH];
    logic        relaxMem_q [DEPTH];
    logic [1:0]  expFmt;
    logic        expRelax;
`else
    // Without the relaxed compare, fmt and relax carry no meaning here.
    logic [2:0] unusedRelaxInputs;
    assign unusedRelaxInputs = {push_fmt, push_relax};
`endif

    // Head-of-queue expectation that the current dut result is judged against.
    assign expResult = resultMem_q[rdPtr_q];
    assign expFlags  = flagsMem_q[rdPtr_q];
    assign expLast   = lastMem_q[rdPtr_q];
`ifdef FP_CHECK_NAN_RELAX_EN
    assign expFmt    = fmtMem_q[rdPtr_q];
    assign expRelax  = relaxMem_q[rdPtr_q];
`endif

    // A simultaneous pop frees a slot, so a full queue can still take a push.
    assign inRun      = (state_q == RUN);
    assign push_ready = (count_q < FullCount) || dut_ready;

    // An empty queue cannot answer a result even if a push arrives in the
    // same cycle: the new entry is never bypassed to the compare.
    assign underflow = inRun && dut_ready && (count_q == '0);
    assign overflow  = inRun && push_valid && !push_ready;
    assign popOk     = inRun && dut_ready && (count_q != '0);
    assign mismatch  = popOk && ((cmpDiffResult != 64'h0) || (cmpDiffFlags != 5'h0));
    assign doPush    = inRun && push_valid && push_ready;
    assign doPop     = popOk;

    // Result difference. The relaxed form only keeps the exponent plus quiet
    // bit, so any quiet NaN expectation matches the canonical NaN returned by
    // the unit regardless of payload and sign.
    always_comb begin
        cmpDiffResult = dut_result ^ expResult;
`ifdef FP_CHECK_NAN_RELAX_EN
        if (expRelax) begin
            if (expFmt == 2'd0) begin
                if (dut_result[31:0] == 32'h7FC0_0000) begin
                    cmpDiffResult = {32'h0, 1'b0,
                                     dut_result[30:22] ^ expResult[30:22],
                                     22'h0};
                end
            end else if (dut_result == 64'h7FF8_0000_0000_0000) begin
                cmpDiffResult = {1'b0,
                                 dut_result[62:51] ^ expResult[62:51],
                                 51'h0};
            end
        end
`endif
    end

    assign cmpDiffFlags = dut_flags ^ expFlags;

    // Next state and captured status. Errors are prioritised underflow,
    // overflow, mismatch; diffs are only captured by a failing compare.
    always_comb begin
        state_d      = state_q;
        errCode_d    = errCode_q;
        diffResult_d = diffResult_q;
        diffFlags_d  = diffFlags_q;
        checkCount_d = checkCount_q;
        if (inRun) begin
            if (underflow) begin
                state_d   = FAIL;
                errCode_d = ErrUnderflow;
            end else if (overflow) begin
                state_d   = FAIL;
                errCode_d = ErrOverflow;
            end else if (mismatch) begin
                state_d      = FAIL;
                errCode_d    = ErrMismatch;
                diffResult_d = cmpDiffResult;
                diffFlags_d  = cmpDiffFlags;
            end else if (popOk) begin
                if (checkCount_q != 32'hFFFF_FFFF) begin
                    checkCount_d = checkCount_q + 32'd1;
                end
                if (expLast) begin
                    state_d = PASS;
                end
            end
        end
    end

    // State and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            errCode_q    <= ErrNone;
            diffResult_q <= 64'h0;
            diffFlags_q  <= 5'h0;
            checkCount_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            errCode_q    <= errCode_d;
            diffResult_q <= diffResult_d;
            diffFlags_q  <= diffFlags_d;
            checkCount_q <= checkCount_d;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a
    // power of two. Nothing moves once the test has ended.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (!doPush && doPop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage; stale contents are harmless because occupancy gates use.
    always_ff @(posedge clock) begin
        if (doPush) begin
            resultMem_q[wrPtr_q] <= push_result;
            flagsMem_q[wrPtr_q]  <= push_flags;
            lastMem_q[wrPtr_q]   <= push_last;
`ifdef FP_CHECK_NAN_RELAX_EN
            fmtMem_q[wrPtr_q]    <= push_fmt;
            relaxMem_q[wrPtr_q]  <= push_relax;
`endif
        end
    end

    assign done        = (state_q != RUN);
    assign fail        = (state_q == FAIL);
    assign err_code    = errCode_q;
    assign diff_result = diffResult_q;
    assign diff_flags  = diffFlags_q;
    assign check_count = checkCount_q;

endmodule

// File: tb/tb_fp_check_queue.sv
// ---------------------------------------------------------------------------
// tb_fp_check_queue
//
// Directed bench for fp_check_queue (DEPTH = 8). A single linear sequence of
// steps drives the queue and compares each output with a hand-computed value.
// Honours FP_CHECK_NAN_RELAX_EN for the NaN-relaxed scenario.
// ---------------------------------------------------------------------------
module tb_fp_check_queue;

    logic        clock;
    logic        reset;
    logic        push_valid;
    logic [63:0] push_result;
    logic [4:0]  push_flags;
    logic [1:0]  push_fmt;
    logic        push_relax;
    logic        push_last;
    logic        dut_ready;
    logic [63:0] dut_result;
    logic [4:0]  dut_flags;
    logic        push_ready;
    logic        done;
    logic        fail;
    logic [1:0]  err_code;
    logic [63:0] diff_result;
    logic [4:0]  diff_flags;
    logic [31:0] check_count;

    int checks   = 0;
    int failures = 0;

    fp_check_queue #(.DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_result (push_result),
        .push_flags  (push_flags),
        .push_fmt    (push_fmt),
        .push_relax  (push_relax),
        .push_last   (push_last),
        .dut_ready   (dut_ready),
        .dut_result  (dut_result),
        .dut_flags   (dut_flags),
        .push_ready  (push_ready),
        .done        (done),
        .fail        (fail),
        .err_code    (err_code),
        .diff_result (diff_result),
        .diff_flags  (diff_flags),
        .check_count (check_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive every input for the next clock edge.
    task automatic applyStimulus(input logic pv, input logic [63:0] pr,
                                 input logic [4:0] pf, input logic [1:0] fmt,
                                 input logic relax, input logic last,
                                 input logic dr, input logic [63:0] dres,
                                 input logic [4:0] dfl);
        push_valid  = pv;
        push_result = pr;
        push_flags  = pf;
        push_fmt    = fmt;
        push_relax  = relax;
        push_last   = last;
        dut_ready   = dr;
        dut_result  = dres;
        dut_flags   = dfl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 5'h0);
    endtask

    // Advance one edge and sample 1 ns later, away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".done"},        64'(done),        64'h0);
        checkOutput({tag, ".fail"},        64'(fail),        64'h0);
        checkOutput({tag, ".err_code"},    64'(err_code),    64'h0);
        checkOutput({tag, ".diff_result"}, diff_result,      64'h0);
        checkOutput({tag, ".diff_flags"},  64'(diff_flags),  64'h0);
        checkOutput({tag, ".check_count"}, 64'(check_count), 64'h0);
        checkOutput({tag, ".push_ready"},  64'(push_ready),  64'h1);
    endtask

    // Synchronous-looking pulse of the asynchronous reset.
    task automatic doReset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic        relaxExpFail;
    logic [1:0]  relaxExpErr;
    logic [63:0] relaxExpDiff;
    logic [31:0] relaxExpCount;

    initial begin
        idle();
        reset = 1'b1;
        #1;
        $display("[TB] reset state");
        checkResetState("reset");
        tick();
        reset = 1'b0;

        // Basic single-precision pass, result four cycles after the push.
        $display("[TB] single matching compare");
        applyStimulus(1'b1, 64'h3F80_0000, 5'h0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 5'h0);
        #1;
        checkOutput("basic.push_ready", 64'(push_ready), 64'h1);
        tick();
        idle();
        repeat (3) tick();
        checkOutput("basic.done_early", 64'(done), 64'h0);
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h3F80_0000, 5'h0);
        tick();
        idle();
        checkOutput("basic.done",        64'(done),        64'h1);
        checkOutput("basic.fail",        64'(fail),        64'h0);
        checkOutput("basic.err_code",    64'(err_code),    64'h0);
        checkOutput("basic.check_count", 64'(check_count), 64'h1);

        // PASS is terminal: a result with an empty queue must not underflow.
        applyStimulus(1'b1, 64'h1234, 5'h3, 2'd1, 1'b0, 1'b0, 1'b1, 64'h9999, 5'h1);
        tick();
        idle();
        checkOutput("frozen.err_code",    64'(err_code),    64'h0);
        checkOutput("frozen.fail",        64'(fail),        64'h0);
        checkOutput("frozen.check_count", 64'(check_count), 64'h1);

        // Quiet NaN with payload vs canonical NaN.
        $display("[TB] NaN relaxed compare");
        doReset();
`ifdef FP_CHECK_NAN_RELAX_EN
        relaxExpFail  = 1'b0;
        relaxExpErr   = 2'd0;
        relaxExpDiff  = 64'h0;
        relaxExpCount = 32'd1;
`else
        relaxExpFail  = 1'b1;
        relaxExpErr   = 2'd1;
        relaxExpDiff  = 64'h1;
        relaxExpCount = 32'd0;
`endif
        applyStimulus(1'b1, 64'h7FC0_0001, 5'h0, 2'd0, 1'b1, 1'b1, 1'b0, 64'h0, 5'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h7FC0_0000, 5'h0);
        tick();
        idle();
        checkOutput("nan.done",        64'(done),        64'h1);
        checkOutput("nan.fail",        64'(fail),        64'(relaxExpFail));
        checkOutput("nan.err_code",    64'(err_code),    64'(relaxExpErr));
        checkOutput("nan.diff_result", diff_result,      relaxExpDiff);
        checkOutput("nan.check_count", 64'(check_count), 64'(relaxExpCount));

        // Flag-only mismatch, then diffs must hold.
        $display("[TB] flag mismatch");
        doReset();
        applyStimulus(1'b1, 64'h4000_0000_0000_0000, 5'h01, 2'd1, 1'b0, 1'b1, 1'b0, 64'h0, 5'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h4000_0000_0000_0000, 5'h00);
        tick();
        idle();
        checkOutput("flags.done",        64'(done),        64'h1);
        checkOutput("flags.fail",        64'(fail),        64'h1);
        checkOutput("flags.err_code",    64'(err_code),    64'h1);
        checkOutput("flags.diff_flags",  64'(diff_flags),  64'h01);
        checkOutput("flags.diff_result", diff_result,      64'h0);
        checkOutput("flags.check_count", 64'(check_count), 64'h0);
        applyStimulus(1'b1, 64'h5, 5'h1F, 2'd0, 1'b0, 1'b1, 1'b1, 64'hFF, 5'h0);
        tick();
        idle();
        checkOutput("flags.hold_flags",  64'(diff_flags),  64'h01);
        checkOutput("flags.hold_result", diff_result,      64'h0);
        checkOutput("flags.hold_err",    64'(err_code),    64'h1);

        // Overflow: ninth push into a full queue without a pop.
        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h200 + 64'(i), 5'h0, 2'd1, 1'b0, 1'b0, 1'b0, 64'h0, 5'h0);
            tick();
        end
        applyStimulus(1'b1, 64'h208, 5'h0, 2'd1, 1'b0, 1'b1, 1'b0, 64'h0, 5'h0);
        #1;
        checkOutput("ovf.push_ready", 64'(push_ready), 64'h0);
        tick();
        idle();
        checkOutput("ovf.err_code",    64'(err_code),   64'h3);
        checkOutput("ovf.fail",        64'(fail),       64'h1);
        checkOutput("ovf.done",        64'(done),       64'h1);
        checkOutput("ovf.diff_result", diff_result,     64'h0);
        checkOutput("ovf.diff_flags",  64'(diff_flags), 64'h0);

        // Full queue with a simultaneous pop accepts the ninth push.
        $display("[TB] push and pop at full");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h100 + 64'(i), 5'h0, 2'd1, 1'b0, 1'b0, 1'b0, 64'h0, 5'h0);
            tick();
        end
        applyStimulus(1'b1, 64'h108, 5'h0, 2'd1, 1'b0, 1'b1, 1'b1, 64'h100, 5'h0);
        #1;
        checkOutput("full.push_ready_pop", 64'(push_ready), 64'h1);
        tick();
        idle();
        #1;
        checkOutput("full.err_code",        64'(err_code),    64'h0);
        checkOutput("full.done",            64'(done),        64'h0);
        checkOutput("full.check_count",     64'(check_count), 64'h1);
        checkOutput("full.push_ready_still", 64'(push_ready), 64'h0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h100 + 64'(i), 5'h0);
            tick();
        end
        idle();
        checkOutput("full.drain_done",  64'(done),        64'h1);
        checkOutput("full.drain_fail",  64'(fail),        64'h0);
        checkOutput("full.drain_count", 64'(check_count), 64'h9);

        // Underflow, including a push in the same cycle (no bypass).
        $display("[TB] underflow and mid-run reset");
        doReset();
        applyStimulus(1'b1, 64'h55, 5'h0, 2'd1, 1'b0, 1'b1, 1'b1, 64'h55, 5'h0);
        tick();
        idle();
        checkOutput("udf.err_code",    64'(err_code),    64'h2);
        checkOutput("udf.fail",        64'(fail),        64'h1);
        checkOutput("udf.diff_result", diff_result,      64'h0);
        checkOutput("udf.check_count", 64'(check_count), 64'h0);

        // Asynchronous reset between edges clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async_reset");
        tick();
        reset = 1'b0;

        // An entry in flight when reset hits is discarded.
        applyStimulus(1'b1, 64'h77, 5'h0, 2'd1, 1'b0, 1'b1, 1'b0, 64'h0, 5'h0);
        tick();
        idle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("discard.push_ready", 64'(push_ready), 64'h1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h77, 5'h0);
        tick();
        idle();
        checkOutput("discard.err_code", 64'(err_code), 64'h2);
        checkOutput("discard.fail",     64'(fail),     64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_check_queue.md
FP_CHECK_QUEUE -- requirements
Module: fp_check_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of outstanding expected entries; power of 2, 2..64.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port push_valid  input  1  an operation is issued to fp_unit this cycle; its expected entry is enqueued.
REQ-005 SHALL have port push_result  input  64  expected result.
REQ-006 SHALL have port push_flags  input  5  expected exception flags.
REQ-007 SHALL have port push_fmt  input  2  format; 0 = single, other = double.
REQ-008 SHALL have port push_relax  input  1  NaN-relaxed compare allowed (op is neither fcvt_f2i nor fcmp).
REQ-009 SHALL have port push_last  input  1  final vector marker.
REQ-010 SHALL have port dut_ready  input  1  fp_unit result valid this cycle.
REQ-011 SHALL have port dut_result  input  64  fp_unit result.
REQ-012 SHALL have port dut_flags  input  5  fp_unit flags.
REQ-013 SHALL have port push_ready  output  1  queue can accept push_valid this cycle.
REQ-014 SHALL have port done  output  1  sticky; test finished (pass or fail).
REQ-015 SHALL have port fail  output  1  sticky; qualified by done.
REQ-016 SHALL have port err_code  output  2  0 none, 1 mismatch, 2 underflow, 3 overflow.
REQ-017 SHALL have port diff_result  output  64  captured result difference at failure.
REQ-018 SHALL have port diff_flags  output  5  captured flag difference at failure.
REQ-019 SHALL have port check_count  output  32  number of compares completed with match.

Function
REQ-020 SHALL keep a FIFO of DEPTH entries {result, flags, fmt, relax, last} with read/write pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-021 SHALL drive push_ready = (count < DEPTH) OR dut_ready; push and pop in the same cycle at full SHALL be accepted with count unchanged.
REQ-022 SHALL pop the head entry on every dut_ready while in RUN; push and pop in the same cycle at empty SHALL be an underflow (the new entry is not bypassed).
REQ-023 SHALL use a state machine with states RUN, PASS and FAIL; RUN to FAIL on mismatch, underflow or overflow; RUN to PASS on a matching pop whose last=1; PASS and FAIL are terminal until reset.
REQ-024 SHALL, with the relaxed compare active and fmt=0 and dut_result[31:0]=32'h7FC00000, compute diff = {32'h0, 1'b0, dut[30:22]^exp[30:22], 22'h0}.
REQ-025 SHALL, with the relaxed compare active and fmt!=0 and dut_result=64'h7FF8000000000000, compute diff = {1'b0, dut[62:51]^exp[62:51], 51'h0}.
REQ-026 SHALL otherwise compute diff = dut_result XOR expected result; flag diff = dut_flags XOR expected flags.
REQ-027 SHALL declare a mismatch when either diff is nonzero.
REQ-028 SHALL register compare results, so done/fail/err_code/diff_* update exactly 1 cycle after the dut_ready that caused them.
REQ-029 SHALL set err_code=3 when push_valid=1 and push_ready=0; that entry is dropped.
REQ-030 SHALL, when several errors occur in one cycle, apply priority underflow > overflow > mismatch.
REQ-031 SHALL capture diff_result/diff_flags only on the failing compare and hold them afterwards; they are 0 for underflow and overflow.
REQ-032 SHALL increment check_count by 1 per matching compare, saturating at 32'hFFFFFFFF.
REQ-033 SHALL ignore push_valid and dut_ready in PASS and FAIL; queue contents and count are frozen.

Reset
REQ-034 SHALL, on reset assertion, immediately (asynchronously) set state=RUN, pointers and count=0, done=0, fail=0, err_code=0, diff_result=0, diff_flags=0 and check_count=0; push_ready follows as 1.
REQ-035 SHALL discard all in-flight entries on reset mid-operation; a dut_ready in the first cycle after release is an underflow.

Configuration
REQ-036 SHALL, with macro FP_CHECK_NAN_RELAX_EN defined, activate the relaxed compare of REQ-024/025 whenever the entry's relax=1.
REQ-037 SHALL, without FP_CHECK_NAN_RELAX_EN, ignore push_relax, use the exact compare of REQ-026 only, and not store the relax bit.

Verification
REQ-038 SHALL cover: push exp=64'h3F800000, flags 0, fmt 0, last=1; dut_ready 4 cycles later with the same values -> next cycle done=1, fail=0, check_count=1.
REQ-039 SHALL cover: expected 64'h7FC00001, relax=1, fmt 0; dut=64'h7FC00000 -> pass with macro defined; without the macro -> fail, err_code=1, diff_result=64'h1.
REQ-040 SHALL cover: expected flags 5'h01, dut_flags 5'h00, results equal -> fail, err_code=1, diff_flags=5'h01, diff_result=0.
REQ-041 SHALL cover: DEPTH=8, 8 pushes with no pops, then a 9th push -> push_ready=0, err_code=3; repeat with dut_ready asserted on the 9th push -> accepted, count stays 8.
REQ-042 SHALL cover: dut_ready with the queue empty -> err_code=2 the next cycle; then assert reset mid-run -> all outputs 0 and push_ready=1.
